// File: rtl/seq_byte_fifo_feed_pkg.sv
// rtl/seq_byte_fifo_feed_pkg.sv - shared constants and types for the byte FIFO feeding the enabled register stage
package seq_fifo_pkg;

    localparam int         FIFO_DEPTH_DFLT = 4;
    localparam logic [7:0] BYTE_IDLE       = 8'hff;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/seq_byte_fifo_feed_if.sv
// rtl/seq_byte_fifo_feed_if.sv - enq/deq valid-ready bundle plus occupancy between producer, FIFO and register stage
interface seq_byte_fifo_feed_if
    import seq_fifo_pkg::*;
#(
    parameter int p_depth = FIFO_DEPTH_DFLT,
    parameter int p_nbits = 8
);

    logic                         enq_val;
    logic                         enq_rdy;
    logic [p_nbits-1:0]           enq_msg;
    logic                         deq_val;
    logic                         deq_rdy;
    logic [p_nbits-1:0]           deq_msg;
    logic [$clog2(p_depth+1)-1:0] num_ent;

    // master = producer/consumer side, slave = the FIFO itself
    modport master (
        output enq_val, enq_msg, deq_rdy,
        input  enq_rdy, deq_val, deq_msg, num_ent
    );

    modport slave (
        input  enq_val, enq_msg, deq_rdy,
        output enq_rdy, deq_val, deq_msg, num_ent
    );

endinterface

// File: rtl/seq_byte_fifo_feed_ctrl.sv
// rtl/seq_byte_fifo_feed_ctrl.sv - pointer and occupancy control for the byte FIFO
module seq_fifo_ctrl
    import seq_fifo_pkg::*;
#(
    parameter int p_depth = FIFO_DEPTH_DFLT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_val,
    input  logic                         deq_rdy,
    output logic                         enq_rdy,
    output logic                         deq_val,
    output logic                         wr_en,
    output logic [$clog2(p_depth)-1:0]   wr_addr,
    output logic [$clog2(p_depth)-1:0]   rd_addr,
    output logic [$clog2(p_depth+1)-1:0] num_ent
);

    localparam int             AW       = $clog2(p_depth);
    localparam int             CW       = $clog2(p_depth + 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(p_depth);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          enq_fire, deq_fire;

    // Ready/valid come only from the count, so deq_rdy never reaches enq_rdy.
    always_comb begin
        enq_rdy  = (cnt_q != FULL_CNT);
        deq_val  = (cnt_q != '0);
        enq_fire = enq_val && enq_rdy;
        deq_fire = deq_rdy && deq_val;

        // p_depth is a power of two, so the natural pointer overflow is the wrap
        wr_ptr_d = enq_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = deq_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;

        cnt_d = cnt_q;
        case ({enq_fire, deq_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wr_en   = enq_fire;
    assign wr_addr = wr_ptr_q;
    assign rd_addr = rd_ptr_q;
    assign num_ent = cnt_q;

endmodule

// File: rtl/seq_byte_fifo_feed.sv
// rtl/seq_byte_fifo_feed.sv - 4-entry byte FIFO whose head drives the d/en of a downstream enabled register stage
module seq_byte_fifo_feed
    import seq_fifo_pkg::*;
#(
    parameter int p_depth = FIFO_DEPTH_DFLT,
    parameter int p_nbits = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_byte_fifo_feed_if.slave  q
);

    localparam int AW = $clog2(p_depth);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [AW-1:0]      rd_addr;
    logic [p_nbits-1:0] mem_q [p_depth];

    seq_fifo_ctrl #(
        .p_depth (p_depth)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .enq_val (q.enq_val),
        .deq_rdy (q.deq_rdy),
        .enq_rdy (q.enq_rdy),
        .deq_val (q.deq_val),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .num_ent (q.num_ent)
    );

    // Storage is deliberately unreset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= q.enq_msg;
        end
    end

    // Idle value is all-ones so the stage sees its own reset value when empty.
    assign q.deq_msg = q.deq_val ? mem_q[rd_addr] : {p_nbits{1'b1}};

endmodule

// File: tb/tb_seq_byte_fifo_feed.sv
// tb/tb_seq_byte_fifo_feed.sv - directed and random checks of seq_byte_fifo_feed against a queue model
module tb_seq_byte_fifo_feed;
    import seq_fifo_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    byte_t mdl[$];

    seq_byte_fifo_feed_if #(.p_depth(DEPTH), .p_nbits(8)) fifo_if ();

    seq_byte_fifo_feed #(
        .p_depth (DEPTH),
        .p_nbits (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .q     (fifo_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        byte_t exp_msg;
        exp_msg = (mdl.size() != 0) ? mdl[0] : BYTE_IDLE;
        check_eq({tag, ".enq_rdy"}, 32'(fifo_if.enq_rdy), 32'(mdl.size() != DEPTH));
        check_eq({tag, ".deq_val"}, 32'(fifo_if.deq_val), 32'(mdl.size() != 0));
        check_eq({tag, ".deq_msg"}, 32'(fifo_if.deq_msg), 32'(exp_msg));
        check_eq({tag, ".num_ent"}, 32'(fifo_if.num_ent), 32'(mdl.size()));
    endtask

    // Called at posedge+1; checks pre-edge outputs, then advances one cycle.
    task automatic step(input string tag, input logic ev, input byte_t msg, input logic dr);
        bit do_enq;
        bit do_deq;
        fifo_if.enq_val = ev;
        fifo_if.enq_msg = msg;
        fifo_if.deq_rdy = dr;
        #1;
        check_model(tag);
        do_enq = ev && (mdl.size() < DEPTH);
        do_deq = dr && (mdl.size() > 0);
        @(posedge clk);
        #1;
        if (do_deq) void'(mdl.pop_front());
        if (do_enq) mdl.push_back(msg);
    endtask

    // Asserts reset between edges, checks the immediate effect, holds it across one edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        mdl.delete();
        check_eq({tag, ".rst_enq_rdy"}, 32'(fifo_if.enq_rdy), 32'd1);
        check_eq({tag, ".rst_deq_val"}, 32'(fifo_if.deq_val), 32'd0);
        check_eq({tag, ".rst_deq_msg"}, 32'(fifo_if.deq_msg), 32'hff);
        check_eq({tag, ".rst_num_ent"}, 32'(fifo_if.num_ent), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        fifo_if.enq_val = 1'b0;
        fifo_if.enq_msg = 8'h00;
        fifo_if.deq_rdy = 1'b0;

        do_reset("t1");

        step("t2a", 1'b1, 8'h3c, 1'b0);
        step("t2b", 1'b0, 8'h00, 1'b1);
        step("t2c", 1'b0, 8'h00, 1'b0);

        for (int i = 1; i <= 4; i++) step("t3fill", 1'b1, byte_t'(i), 1'b0);
        check_eq("t3.full_num", 32'(fifo_if.num_ent), 32'd4);
        step("t3ref", 1'b1, 8'h05, 1'b0);
        for (int i = 0; i < 5; i++) step("t3drain", 1'b0, 8'h00, 1'b1);

        for (int i = 1; i <= 4; i++) step("t4fill", 1'b1, byte_t'(i), 1'b0);
        step("t4both", 1'b1, 8'h05, 1'b1);
        check_eq("t4.num_after", 32'(fifo_if.num_ent), 32'd3);
        step("t4enq", 1'b1, 8'h05, 1'b0);
        for (int i = 0; i < 5; i++) step("t4drain", 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 10; i++) step("t5", 1'b1, byte_t'(8'ha0 + i), 1'b1);
        check_eq("t5.num_stream", 32'(fifo_if.num_ent), 32'd1);
        step("t5end", 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 3; i++) step("t6load", 1'b1, byte_t'(8'h50 + i), 1'b0);
        do_reset("t6");
        step("t6enq", 1'b1, 8'h77, 1'b0);
        check_eq("t6.msg77", 32'(fifo_if.deq_msg), 32'h77);
        step("t6deq", 1'b0, 8'h00, 1'b1);

        for (int blk = 0; blk < 12; blk++) begin
            int p_enq;
            int p_deq;
            p_enq = $urandom_range(10, 95);
            p_deq = $urandom_range(10, 95);
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    do_reset("rnd");
                end else begin
                    step("rnd",
                         ($urandom_range(0, 99) < p_enq),
                         byte_t'($urandom),
                         ($urandom_range(0, 99) < p_deq));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
